descriptor_distance_acc: RTL
============================

DESCRIPTOR_DISTANCE_ACC -- requirements
Module: descriptor_distance_acc

Interface
REQ-001 The block SHALL have parameter ELEM_W, default 12: unsigned bit width of one descriptor element.
REQ-002 The block SHALL have parameter DIM, default 128: elements per descriptor; it SHALL be an integer multiple of LANES.
REQ-003 The block SHALL have parameter LANES, default 8: elements consumed per accepted beat; BEATS = DIM/LANES SHALL be at least 2.
REQ-004 The block SHALL have parameter OUT_W, default 14: output width, used only when DIST_SAT_EN is defined.
REQ-005 The block SHALL have derived width DIST_W = ELEM_W + clog2(DIM), the full-precision L1 width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change only on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 The block SHALL have port in_valid, input, 1 bit: the beat on in_a/in_b is valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-010 The block SHALL have port in_a, input, LANES*ELEM_W bits: descriptor A lanes, lane k at [k*ELEM_W +: ELEM_W].
REQ-011 The block SHALL have port in_b, input, LANES*ELEM_W bits: descriptor B lanes, with the same packing as in_a.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out_dist holds a completed distance.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer takes out_dist.
REQ-014 The block SHALL have port out_dist, output: OUT_W bits with DIST_SAT_EN, DIST_W bits without it; it carries the L1 distance.
REQ-015 The block SHALL have port out_sat, output, 1 bit, present only with DIST_SAT_EN: the distance was clipped.
REQ-016 The block SHALL have port busy, output, 1 bit: a descriptor is partially accumulated.

Function
REQ-017 A beat SHALL be accepted on any rising edge where in_valid && in_ready.
REQ-018 For each lane, the block SHALL compute |a-b| unsigned and without wrap (a>b ? a-b : b-a), then sum all LANES lanes at DIST_W width with no truncation.
REQ-019 A beat counter beat_cnt SHALL count 0..BEATS-1; it SHALL increment on each accepted beat and wrap to 0 after the beat accepted at BEATS-1 (the final beat).
REQ-020 On an accepted non-final beat, the accumulator SHALL be loaded with the lane sum when beat_cnt==0, and SHALL otherwise be loaded with acc + lane sum.
REQ-021 On the accepted final beat, out_dist SHALL load acc + lane sum (the lane sum alone if BEATS==1 is excluded), out_valid SHALL be set, and the accumulator is don't-care.
REQ-022 out_valid SHALL rise exactly one cycle after the final-beat handshake edge, i.e. latency 1 from the last beat.
REQ-023 out_valid SHALL clear on an edge with out_valid && out_ready, unless a new final beat is accepted on the same edge, in which case out_valid SHALL stay 1 and out_dist SHALL load the new value.
REQ-024 in_ready SHALL equal !(beat_cnt==BEATS-1 && out_valid && !out_ready).
REQ-025 Non-final beats SHALL never be stalled by output backpressure.
REQ-026 While out_valid=1, out_dist (and out_sat) SHALL remain stable until the output handshake.
REQ-027 busy SHALL equal (beat_cnt != 0).
REQ-028 Idle cycles (in_valid=0) between beats of one descriptor SHALL be allowed and SHALL not change the accumulated value.

Reset
REQ-029 On a clk edge with rst_n=0, the block SHALL clear beat_cnt, the accumulator, out_valid, out_dist, out_sat and busy to 0.
REQ-030 While rst_n=0, in_ready SHALL be driven 1.
REQ-031 A reset mid-descriptor SHALL discard the partial sum; the next accepted beat SHALL be treated as beat 0.

Configuration
REQ-032 Macro DIST_SAT_EN, when defined, SHALL make out_dist = min(full_sum, 2^OUT_W-1), with out_sat=1 exactly when full_sum > 2^OUT_W-1; internal accumulation SHALL stay DIST_W wide.
REQ-033 When DIST_SAT_EN is undefined, out_dist SHALL be the full DIST_W-bit sum, out_sat SHALL be absent, and no clipping logic SHALL exist.

Verification
REQ-034 DIM=32, LANES=8, ELEM_W=12, no macro; A all 4095, B all 0, 4 back-to-back beats, out_ready=1 -> out_dist=131040, out_valid one cycle after beat 4.
REQ-035 Same parameters; each lane A=10, B=13, with 2 idle cycles inserted after beat 2 -> out_dist=96, busy=1 during the gap.
REQ-036 out_ready=0 with a result pending, then a second descriptor streamed -> beats 1-3 accepted, in_ready=0 at beat 4 until out_ready=1; first result unchanged while held.
REQ-037 out_ready=1 while the final beat of the next descriptor is accepted on the same edge -> out_valid stays 1 and out_dist switches to the new sum with no bubble.
REQ-038 rst_n=0 for one cycle after beat 2, then a full descriptor of all-zero differences -> out_dist=0; no stale partial sum.
REQ-039 DIST_SAT_EN, OUT_W=14; A=4095, B=0 -> out_dist=16383, out_sat=1; lanes differing by 100 -> out_dist=3200, out_sat=0.

Source files
------------

// File: rtl/descriptor_distance_acc.sv
// Streaming L1 distance between two descriptors, LANES elements per beat, one result per DIM elements.
// Optional macro DIST_SAT_EN clips out_dist to OUT_W bits and adds the out_sat flag.
module descriptor_distance_acc #(
  parameter int ELEM_W = 12,
  parameter int DIM    = 128,
  parameter int LANES  = 8,
  parameter int OUT_W  = 14
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES*ELEM_W-1:0]         in_a,
  input  logic [LANES*ELEM_W-1:0]         in_b,
  output logic                            out_valid,
  input  logic                            out_ready,
`ifdef DIST_SAT_EN
  output logic [OUT_W-1:0]                out_dist,
  output logic                            out_sat,
`else
  output logic [ELEM_W+$clog2(DIM)-1:0]   out_dist,
`endif
  output logic                            busy
);

  localparam int BEATS  = DIM / LANES;
  localparam int DIST_W = ELEM_W + $clog2(DIM);
  localparam int CNT_W  = $clog2(BEATS);

  // Reject configurations where the beat counter or the lane split makes no sense.
  if ((DIM % LANES) != 0 || BEATS < 2 || OUT_W < 1) begin : g_bad_cfg
    $error("descriptor_distance_acc: DIM must be a multiple of LANES with DIM/LANES >= 2");
  end

  logic [CNT_W-1:0]  beat_cnt_q;
  logic [DIST_W-1:0] acc_q;
  logic              out_valid_q;
  logic [DIST_W-1:0] lane_sum;
  logic [DIST_W-1:0] full_sum;
  logic [ELEM_W-1:0] lane_a;
  logic [ELEM_W-1:0] lane_b;
  logic [ELEM_W-1:0] lane_diff;
  logic              last_beat;
  logic              accept;

  assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));
  assign in_ready  = !rst_n || !(last_beat && out_valid_q && !out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (beat_cnt_q != '0);
  assign out_valid = out_valid_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    lane_sum  = '0;
    lane_a    = '0;
    lane_b    = '0;
    lane_diff = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_a    = in_a[k*ELEM_W +: ELEM_W];
      lane_b    = in_b[k*ELEM_W +: ELEM_W];
      lane_diff = (lane_a > lane_b) ? (lane_a - lane_b) : (lane_b - lane_a);
      lane_sum  = lane_sum + DIST_W'(lane_diff);
    end
  end

  // DIST_W is wide enough for DIM maximal differences, so this sum never wraps.
  assign full_sum = acc_q + lane_sum;

`ifdef DIST_SAT_EN
  localparam int CMP_W = (OUT_W > DIST_W) ? OUT_W : DIST_W;
  localparam logic [CMP_W-1:0] SAT_MAX = CMP_W'({OUT_W{1'b1}});

  logic [CMP_W-1:0] full_ext;
  logic             clip;
  logic [OUT_W-1:0] dist_d;
  logic [OUT_W-1:0] out_dist_q;
  logic             out_sat_q;

  assign full_ext = CMP_W'(full_sum);
  assign clip     = (full_ext > SAT_MAX);
  assign dist_d   = clip ? OUT_W'(SAT_MAX) : OUT_W'(full_ext);
  assign out_sat  = out_sat_q;
`else
  logic [DIST_W-1:0] dist_d;
  logic [DIST_W-1:0] out_dist_q;

  assign dist_d = full_sum;
`endif

  assign out_dist = out_dist_q;

  // NOTE: sequential state uses non-blocking assignments only; the later out_valid_q write wins on a same-edge handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // The accumulator is cleared too, so a reset mid-descriptor leaves no trace of the partial sum.
      beat_cnt_q  <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_dist_q  <= '0;
`ifdef DIST_SAT_EN
      out_sat_q   <= 1'b0;
`endif
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        if (last_beat) begin
          beat_cnt_q  <= '0;
          out_valid_q <= 1'b1;
          out_dist_q  <= dist_d;
`ifdef DIST_SAT_EN
          out_sat_q   <= clip;
`endif
        end else begin
          beat_cnt_q <= beat_cnt_q + CNT_W'(1);
          acc_q      <= (beat_cnt_q == '0) ? lane_sum : full_sum;
        end
      end
    end
  end

endmodule
